pps_generator: RTL and testbench

- Transmit side of the PPS interface. Watches the free-running 64-bit timestamp and drives a PPS output pulse at each second boundary, shifted by a programmable fractional phase offset.
- Sits beside the stamp counter, fed by STAMP_COUNTER. Configuration and status connect through rw/ro registers in the wrapper.
- Lets one board discipline another board, or external test equipment, to its own time base.

---
 rtl/pps_generator_pkg.sv | 31 +++
 rtl/pps_pulse_stretch.sv | 41 ++++
 rtl/pps_generator.sv | 142 ++++++++++++++
 tb/tb_pps_generator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pps_generator_pkg.sv
// rtl/pps_generator_pkg.sv - shared constants and types for the PPS transmit block
// Purpose: field split of the timestamp, FSM state encoding and wrapper register map.
// Ports: none (package).
package pps_generator_pkg;

    localparam int DEF_TIMESTAMP_WIDTH  = 64;
    localparam int DEF_FRAC_WIDTH       = 32;
    localparam int DEF_PULSE_WIDTH_BITS = 32;

    // Seconds occupy the upper part of the timestamp, fraction the lower part.
    localparam int SEC_LSB = DEF_FRAC_WIDTH;
    localparam int SEC_MSB = DEF_TIMESTAMP_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIGH  = 2'd2
    } pps_state_t;

    // Wrapper register map (byte offsets) and bit positions.
    localparam logic [7:0] REG_RW0_CTRL        = 8'h00;
    localparam logic [7:0] REG_RW1_PULSE_WIDTH = 8'h04;
    localparam logic [7:0] REG_RW2_PHASE       = 8'h08;
    localparam logic [7:0] REG_RO0_STATUS      = 8'h0C;

    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_POLARITY_BIT = 1;
    localparam int STATUS_MISSED_BIT = 0;
    localparam int STATUS_JUMP_BIT   = 1;

endpackage

// File: rtl/pps_pulse_stretch.sv
// rtl/pps_pulse_stretch.sv - loadable down-counter that holds the PPS active window
// Purpose: after load, active is high for exactly max(length,1) cycles; abort ends it.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   load         start a window of 'length' cycles (0 treated as 1)
//   length       window length in clock cycles
//   abort        clear the window immediately (takes priority over load)
//   active       window is open
//   last         final cycle of the window
module pps_pulse_stretch #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] length,
    input  logic             abort,
    output logic             active,
    output logic             last
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (abort) begin
            count <= '0;
        end else if (load) begin
            count <= (length == '0) ? ONE : length;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign active = (count != '0);
    assign last   = (count == ONE);

endmodule

// File: rtl/pps_generator.sv
// rtl/pps_generator.sv - PPS transmitter driven by the free-running timestamp
// Purpose: fires pps_tx at each second boundary shifted by phase_offset, with
//          jump detection and sticky status.
// Ports:
//   axi_aclk, axi_resetn  clock and asynchronous active-low reset
//   stamp_counter         current time {seconds, fraction}
//   enable, polarity      arm generation / output polarity (1 = active low)
//   pulse_width           pulse length in cycles, sampled when a pulse fires
//   phase_offset          fraction within the second at which the pulse starts
//   clear_status          strobe clearing pps_count and sticky flags
//   pps_tx                PPS output
//   pps_count             pulses emitted
//   missed_second         sticky: a scheduled pulse was skipped
//   time_jump             sticky: time moved backwards past the schedule
module pps_generator
    import pps_generator_pkg::*;
#(
    parameter int TIMESTAMP_WIDTH  = 64,
    parameter int FRAC_WIDTH       = 32,
    parameter int PULSE_WIDTH_BITS = 32
) (
    input  logic                        axi_aclk,
    input  logic                        axi_resetn,
    input  logic [TIMESTAMP_WIDTH-1:0]  stamp_counter,
    input  logic                        enable,
    input  logic                        polarity,
    input  logic [PULSE_WIDTH_BITS-1:0] pulse_width,
    input  logic [FRAC_WIDTH-1:0]       phase_offset,
    input  logic                        clear_status,
    output logic                        pps_tx,
    output logic [PULSE_WIDTH_BITS-1:0] pps_count,
    output logic                        missed_second,
    output logic                        time_jump
);

    localparam int SEC_W = TIMESTAMP_WIDTH - FRAC_WIDTH;
    localparam logic [SEC_W-1:0]              SEC_ONE   = {{(SEC_W-1){1'b0}}, 1'b1};
    localparam logic [SEC_W:0]                SEC_ONE_X = {{SEC_W{1'b0}}, 1'b1};
    localparam logic [PULSE_WIDTH_BITS-1:0]   CNT_ONE   = {{(PULSE_WIDTH_BITS-1){1'b0}}, 1'b1};

    pps_state_t             state;
    logic [SEC_W-1:0]       target_sec;
    logic [SEC_W-1:0]       stamp_sec;
    logic [SEC_W-1:0]       arm_sec;
    logic [FRAC_WIDTH-1:0]  stamp_frac;
    logic                   reached;
    logic                   fwd_jump;
    logic                   back_jump;
    logic                   fire;
    logic                   skip;
    logic                   rejump;
    logic                   active;
    logic                   last;

    assign stamp_sec  = stamp_counter[TIMESTAMP_WIDTH-1:FRAC_WIDTH];
    assign stamp_frac = stamp_counter[FRAC_WIDTH-1:0];

    // phase_offset is used live, so a change applies at the next comparison.
    assign reached = (stamp_counter >= {target_sec, phase_offset});

    // Arming never schedules a pulse in the past of the current second.
    assign arm_sec = (stamp_frac >= phase_offset) ? stamp_sec + SEC_ONE : stamp_sec;

    assign fwd_jump  = (stamp_sec > target_sec);
    // Extra bit keeps stamp_sec+1 from wrapping in the backwards test.
    assign back_jump = (({1'b0, stamp_sec} + SEC_ONE_X) < {1'b0, target_sec});

    assign fire   = enable && (state == ARMED) && reached;
    assign skip   = enable && (state == HIGH) && reached;
    assign rejump = enable && (state == ARMED) && !reached && back_jump;

    pps_pulse_stretch #(
        .WIDTH (PULSE_WIDTH_BITS)
    ) u_stretch (
        .clk    (axi_aclk),
        .rst_n  (axi_resetn),
        .load   (fire),
        .length (pulse_width),
        .abort  (!enable),
        .active (active),
        .last   (last)
    );

    assign pps_tx = active ^ polarity;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state      <= IDLE;
            target_sec <= '0;
        end else if (!enable) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state      <= ARMED;
                    target_sec <= arm_sec;
                end
                ARMED: begin
                    if (reached) begin
                        state      <= HIGH;
                        target_sec <= fwd_jump ? stamp_sec + SEC_ONE : target_sec + SEC_ONE;
                    end else if (back_jump) begin
                        target_sec <= arm_sec;
                    end
                end
                HIGH: begin
                    // A boundary landing inside a pulse is dropped, not deferred.
                    if (reached) begin
                        target_sec <= target_sec + SEC_ONE;
                    end
                    if (last) begin
                        state <= ARMED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            pps_count     <= '0;
            missed_second <= 1'b0;
            time_jump     <= 1'b0;
        end else if (clear_status) begin
            pps_count     <= fire ? CNT_ONE : '0;
            missed_second <= 1'b0;
            time_jump     <= 1'b0;
        end else begin
            if (fire) begin
                pps_count <= pps_count + CNT_ONE;
            end
            if (skip || (fire && fwd_jump)) begin
                missed_second <= 1'b1;
            end
            if (rejump) begin
                time_jump <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pps_generator.sv
// tb/tb_pps_generator.sv - self-checking bench for pps_generator
module tb_pps_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] stamp;
    logic        en;
    logic        pol;
    logic [31:0] pw;
    logic [31:0] ph;
    logic        clr;
    logic        pps_tx;
    logic [31:0] pps_count;
    logic        missed;
    logic        jump;

    int tests = 0;
    int fails = 0;
    int ticks = 0;

    // Reference model: second-level schedule plus remaining pulse cycles.
    bit          m_on;
    logic [31:0] m_tsec;
    int unsigned m_left;
    logic [31:0] m_count;
    bit          m_missed;
    bit          m_jump;

    int act_cycles;
    int first_act;
    int last_rise;
    bit prev_act;
    int t0;

    always #5 clk = ~clk;

    pps_generator dut (
        .axi_aclk      (clk),
        .axi_resetn    (rst_n),
        .stamp_counter (stamp),
        .enable        (en),
        .polarity      (pol),
        .pulse_width   (pw),
        .phase_offset  (ph),
        .clear_status  (clr),
        .pps_tx        (pps_tx),
        .pps_count     (pps_count),
        .missed_second (missed),
        .time_jump     (jump)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, exp, ticks);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_tsec = '0; m_left = 0; m_count = '0; m_missed = 0; m_jump = 0;
    endtask

    task automatic model_step();
        logic [31:0] sec;
        logic [31:0] frac;
        logic [31:0] arm;
        int unsigned left_before;
        bit fire;
        bit ms;
        bit js;
        sec = stamp[63:32];
        frac = stamp[31:0];
        arm = (frac >= ph) ? sec + 32'd1 : sec;
        left_before = m_left;
        fire = 0; ms = 0; js = 0;
        if (!en) begin
            m_on = 0;
            m_left = 0;
        end else if (!m_on) begin
            m_on = 1;
            m_tsec = arm;
        end else begin
            if (stamp >= {m_tsec, ph}) begin
                if (left_before != 0) begin
                    ms = 1;
                    m_tsec = m_tsec + 32'd1;
                end else begin
                    fire = 1;
                    if (sec > m_tsec) begin
                        ms = 1;
                        m_tsec = sec + 32'd1;
                    end else begin
                        m_tsec = m_tsec + 32'd1;
                    end
                end
            end else if (left_before == 0 && (longint'(sec) + 1) < longint'(m_tsec)) begin
                js = 1;
                m_tsec = arm;
            end
            if (left_before != 0) m_left = left_before - 1;
            if (fire) m_left = (pw == 0) ? 1 : pw;
        end
        if (clr) begin
            m_count = fire ? 32'd1 : 32'd0;
            m_missed = 0;
            m_jump = 0;
        end else begin
            if (fire) m_count = m_count + 32'd1;
            if (ms) m_missed = 1;
            if (js) m_jump = 1;
        end
    endtask

    task automatic check_all();
        chk("pps_tx", 32'(pps_tx), 32'((m_left != 0) ^ pol));
        chk("pps_count", pps_count, m_count);
        chk("missed_second", 32'(missed), 32'(m_missed));
        chk("time_jump", 32'(jump), 32'(m_jump));
    endtask

    task automatic track_reset();
        act_cycles = 0; first_act = -1; last_rise = -1; prev_act = 0;
    endtask

    task automatic tick();
        bit act;
        model_step();
        @(posedge clk);
        #1;
        ticks++;
        check_all();
        act = ((pps_tx ^ pol) === 1'b1);
        if (act) begin
            act_cycles++;
            if (first_act < 0) first_act = ticks;
            if (!prev_act) last_rise = ticks;
        end
        prev_act = act;
    endtask

    task automatic run(input int n, input logic [63:0] inc);
        for (int i = 0; i < n; i++) begin
            tick();
            stamp = stamp + inc;
        end
    endtask

    task automatic quiesce();
        en = 0; tick();
        clr = 1; tick();
        clr = 0;
    endtask

    initial begin
        rst_n = 0; stamp = '0; en = 0; pol = 0; pw = 32'd1; ph = '0; clr = 0;
        model_reset();
        track_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pps_tx", 32'(pps_tx), 32'd0);
        chk("reset_count", pps_count, 32'd0);
        chk("reset_missed", 32'(missed), 32'd0);
        chk("reset_jump", 32'(jump), 32'd0);
        rst_n = 1;

        // 1. Basic pulse: target {6,0}, 10-cycle high pulse.
        pw = 32'd10; ph = '0; stamp = {32'd5, 32'h8000_0000};
        en = 1; track_reset(); t0 = ticks;
        run(160, 64'h0000_0000_0100_0000);
        // Stamp {6,0} is driven on tick 129; pps_tx is active in the following cycle.
        chk("t1_rise_tick", 32'(first_act), 32'(t0 + 129));
        chk("t1_width", 32'(act_cycles), 32'd10);
        chk("t1_count", pps_count, 32'd1);

        // 2. Phase offset with active-low polarity.
        quiesce();
        pol = 1; ph = 32'h4000_0000; pw = 32'd3; stamp = {32'd7, 32'h1000_0000};
        #1;
        chk("t2_idle_high", 32'(pps_tx), 32'd1);
        en = 1; track_reset(); t0 = ticks;
        run(320, 64'h0000_0000_0100_0000);
        chk("t2_first_rise", 32'(first_act), 32'(t0 + 49));
        chk("t2_second_rise", 32'(last_rise), 32'(t0 + 305));
        chk("t2_active_cycles", 32'(act_cycles), 32'd6);
        chk("t2_count", pps_count, 32'd2);

        // 3. Forward jump from target {9,0} to stamp {12,0x10}.
        quiesce();
        pol = 0; ph = '0; pw = 32'd2; stamp = {32'd8, 32'h8000_0000};
        en = 1; tick();
        stamp = {32'd8, 32'h9000_0000}; tick();
        chk("t3_no_early", pps_count, 32'd0);
        stamp = {32'd12, 32'h0000_0010}; tick();
        chk("t3_fired", 32'(pps_tx), 32'd1);
        chk("t3_missed", 32'(missed), 32'd1);
        stamp = {32'd12, 32'hFFFF_FFF0}; run(3, 64'd0);
        chk("t3_hold", pps_count, 32'd1);
        stamp = {32'd13, 32'h0}; tick();
        chk("t3_next_target", pps_count, 32'd2);

        // 4. Backward jump from target {20,0} to stamp {3,0x10}.
        quiesce();
        stamp = {32'd19, 32'h0000_0010};
        en = 1; tick();
        stamp = {32'd3, 32'h0000_0010}; tick();
        chk("t4_jump", 32'(jump), 32'd1);
        chk("t4_no_pulse", 32'(pps_tx), 32'd0);
        chk("t4_count0", pps_count, 32'd0);
        stamp = {32'd3, 32'hFFFF_FFFF}; run(2, 64'd0);
        chk("t4_still0", pps_count, 32'd0);
        stamp = {32'd4, 32'h0}; tick();
        chk("t4_new_target", pps_count, 32'd1);

        // 5. Zero width gives one cycle; disable truncates a long pulse.
        quiesce();
        pw = 32'd0; stamp = {32'd30, 32'h8000_0000};
        en = 1; tick();
        track_reset();
        stamp = {32'd31, 32'h0}; run(5, 64'd0);
        chk("t5_zero_width", 32'(act_cycles), 32'd1);
        pw = 32'd100; stamp = {32'd32, 32'h0};
        run(4, 64'd0);
        chk("t5_mid_pulse", 32'(pps_tx), 32'd1);
        en = 0; tick();
        chk("t5_abort", 32'(pps_tx), 32'd0);
        chk("t5_idle", 32'(dut.state), 32'd0);

        // 6. Clear coinciding with a pulse, then async reset mid-pulse.
        quiesce();
        pol = 0; pw = 32'd5; stamp = {32'd40, 32'h8000_0000};
        en = 1; tick();
        stamp = {32'd45, 32'h0}; run(7, 64'd0);
        stamp = {32'd2, 32'h0}; tick();
        chk("t6_flags_set", 32'({missed, jump}), 32'd3);
        stamp = {32'd3, 32'h0}; clr = 1; tick();
        clr = 0;
        chk("t6_count", pps_count, 32'd1);
        chk("t6_missed", 32'(missed), 32'd0);
        chk("t6_jump", 32'(jump), 32'd0);
        tick();
        chk("t6_pulse_on", 32'(pps_tx), 32'd1);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("t6_rst_pps_tx", 32'(pps_tx), 32'd0);
        chk("t6_rst_count", pps_count, 32'd0);
        chk("t6_rst_flags", 32'({missed, jump}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // Randomized run against the model.
        en = 1; pw = 32'd3; ph = '0; stamp = {32'd10, 32'h0};
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3)
                stamp = {32'($urandom_range(0, 60)), 32'($urandom)};
            else
                stamp = stamp + {32'd0, 32'h0400_0000 + 32'($urandom_range(0, 255))};
            if ($urandom_range(0, 199) == 0) en = ~en;
            clr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 299) == 0) pol = ~pol;
            if ($urandom_range(0, 199) == 0) ph = 32'($urandom);
            if ($urandom_range(0, 49) == 0) pw = 32'($urandom_range(0, 8));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
